// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and HD44780 command constants for the LCD refresh sequencer.
package lcd_pkg;
  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_CLRW, S_IDLE, S_ADDR1, S_DATA1, S_ADDR2, S_DATA2
  } lcd_state_t;
  localparam logic [7:0] LCD_INIT0 = 8'h33;
  localparam logic [7:0] LCD_INIT1 = 8'h32;
  localparam logic [7:0] LCD_INIT2 = 8'h28;
  localparam logic [7:0] LCD_INIT3 = 8'h0C;
  localparam logic [7:0] LCD_INIT4 = 8'h06;
  localparam logic [7:0] LCD_INIT5 = 8'h01;
  localparam int         LCD_INIT_LEN = 6;
  localparam logic [7:0] LCD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_LINE2 = 8'hC0;
  localparam logic [7:0] LCD_SPACE = 8'h20;
  localparam int         LCD_COLS  = 16;
  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    init_cmd = LCD_INIT0;
      3'd1:    init_cmd = LCD_INIT1;
      3'd2:    init_cmd = LCD_INIT2;
      3'd3:    init_cmd = LCD_INIT3;
      3'd4:    init_cmd = LCD_INIT4;
      default: init_cmd = LCD_INIT5;
    endcase
  endfunction
endpackage

// File: rtl/lcd_char_sel.sv
// lcd_char_sel: picks one character of a 16-byte row (char 0 in the MSBs), showing NUL as a space.
module lcd_char_sel
  import lcd_pkg::*;
(
  input  logic [127:0] i_row,
  input  logic [3:0]   i_idx,
  output logic [7:0]   o_char
);
  logic [6:0] w_lo;
  logic [7:0] w_byte;
  // char i sits at bit offset 8*(15-i), and 15-i is just ~i for a 4-bit index
  assign w_lo   = {~i_idx, 3'b000};
  assign w_byte = i_row[w_lo +: 8];
  assign o_char = (w_byte == 8'h00) ? LCD_SPACE : w_byte;
endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: runs HD44780 4-bit init once, then streams two 16-char rows
// as command/data bytes over valid/ready whenever the text changes or a redraw is requested.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT = 2_000_000,
  parameter int CLR_WAIT = 100_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  input  logic         refresh_req,
  output logic         lcd_valid,
  input  logic         lcd_ready,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         init_done,
  output logic         busy
);
  localparam int WW = (PWR_WAIT > 2) ? $clog2(PWR_WAIT) : 1;

  lcd_state_t   r_state, n_state;
  logic [4:0]   r_idx, n_idx;
  logic [WW-1:0] r_wait, n_wait;
  logic         r_valid, n_valid;
  logic [7:0]   r_data, n_data;
  logic         r_rs, n_rs;
  logic         r_done, n_done;
  logic         r_busy;
  logic         r_force, n_force;
  logic [127:0] r_sh1, n_sh1, r_sh2, n_sh2;
  logic         w_acc, w_last, w_start;
  logic [127:0] w_row;
  logic [3:0]   w_cidx;
  logic [7:0]   w_char;

  // the single selector always looks up the byte that follows the one being accepted
  assign w_row  = (r_state == S_ADDR1 || r_state == S_DATA1) ? r_sh1 : r_sh2;
  assign w_cidx = (r_state == S_ADDR1 || r_state == S_ADDR2) ? 4'd0 : 4'(r_idx + 5'd1);
  assign w_acc   = r_valid & lcd_ready;
  assign w_last  = r_idx == 5'(LCD_COLS - 1);
  assign w_start = (r_sh1 != row1) || (r_sh2 != row2) || r_force;

  lcd_char_sel u_sel (
    .i_row  (w_row),
    .i_idx  (w_cidx),
    .o_char (w_char)
  );

  always_comb begin
    n_state = r_state;
    n_idx   = r_idx;
    n_wait  = r_wait + 1'b1;
    n_valid = r_valid;
    n_data  = r_data;
    n_rs    = r_rs;
    n_done  = r_done;
    n_force = r_force | refresh_req;
    n_sh1   = r_sh1;
    n_sh2   = r_sh2;
    case (r_state)
      S_PWR: if (r_wait == WW'(PWR_WAIT - 1)) begin
        n_state = S_INIT;
        n_idx   = 5'd0;
        n_valid = 1'b1;
        n_data  = init_cmd(3'd0);
        n_rs    = 1'b0;
      end
      S_INIT: if (w_acc) begin
        if (r_idx == 5'(LCD_INIT_LEN - 1)) begin
          n_state = S_CLRW;
          n_wait  = '0;
          n_valid = 1'b0;
        end else begin
          n_idx  = r_idx + 5'd1;
          n_data = init_cmd(3'(r_idx + 5'd1));
        end
      end
      S_CLRW: if (r_wait == WW'(CLR_WAIT - 1)) begin
        n_state = S_IDLE;
        n_done  = 1'b1;
      end
      S_IDLE: if (w_start) begin
        n_sh1   = row1;
        n_sh2   = row2;
        n_force = refresh_req;
        n_state = S_ADDR1;
        n_valid = 1'b1;
        n_data  = LCD_LINE1;
        n_rs    = 1'b0;
      end
      S_ADDR1, S_ADDR2: if (w_acc) begin
        n_state = (r_state == S_ADDR1) ? S_DATA1 : S_DATA2;
        n_idx   = 5'd0;
        n_data  = w_char;
        n_rs    = 1'b1;
      end
      S_DATA1: if (w_acc) begin
        n_state = w_last ? S_ADDR2 : S_DATA1;
        n_idx   = r_idx + 5'd1;
        n_data  = w_last ? LCD_LINE2 : w_char;
        n_rs    = ~w_last;
      end
      S_DATA2: if (w_acc) begin
        n_state = w_last ? S_IDLE : S_DATA2;
        n_idx   = r_idx + 5'd1;
        n_data  = w_char;
        n_valid = ~w_last;
      end
      default: n_state = S_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_PWR;
      r_idx   <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_force <= 1'b0;
      r_sh1   <= {LCD_COLS{LCD_SPACE}};
      r_sh2   <= {LCD_COLS{LCD_SPACE}};
    end else begin
      r_state <= n_state;
      r_idx   <= n_idx;
      r_wait  <= n_wait;
      r_valid <= n_valid;
      r_data  <= n_data;
      r_rs    <= n_rs;
      r_done  <= n_done;
      r_busy  <= n_state != S_IDLE;
      r_force <= n_force;
      r_sh1   <= n_sh1;
      r_sh2   <= n_sh2;
    end
  end

  assign lcd_valid = r_valid;
  assign lcd_data  = r_data;
  assign lcd_rs    = r_rs;
  assign init_done = r_done;
  assign busy      = r_busy;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: scoreboard bench for the LCD refresh sequencer with short wait parameters.
module tb_lcd_refresh_ctrl;
  typedef struct packed {
    logic        rs;
    logic [7:0]  d;
    int unsigned c;
  } rx_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] row1, row2;
  logic         refresh_req;
  logic         lcd_valid, lcd_ready, lcd_rs, init_done, busy;
  logic [7:0]   lcd_data;

  int          total = 0;
  int          errs  = 0;
  int unsigned cyc   = 0;
  int          viol  = 0;
  logic        stalled = 1'b0;
  logic [8:0]  held;
  logic [8:0]  exp_q[$];
  rx_t         rx[$];

  localparam logic [127:0] BLANK  = {16{8'h20}};
  localparam logic [127:0] COTTON = "   Cotton       ";
  localparam logic [127:0] TIMER  = "  Timer 30min   ";
  localparam logic [127:0] WOODY  = "    Woody       ";

  lcd_refresh_ctrl #(.PWR_WAIT(10), .CLR_WAIT(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .row1        (row1),
    .row2        (row2),
    .refresh_req (refresh_req),
    .lcd_valid   (lcd_valid),
    .lcd_ready   (lcd_ready),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .init_done   (init_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!rst) stalled = 1'b0;
    else begin
      if (stalled && (!lcd_valid || {lcd_rs, lcd_data} !== held)) viol++;
      if (lcd_valid && lcd_ready) rx.push_back('{lcd_rs, lcd_data, cyc});
      stalled = lcd_valid && !lcd_ready;
      held    = {lcd_rs, lcd_data};
    end
  end

  function automatic void push_frame(input logic [127:0] r1, input logic [127:0] r2);
    logic [7:0] b;
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) begin
      b = r1[127 - 8*i -: 8];
      exp_q.push_back({1'b1, (b == 8'h00) ? 8'h20 : b});
    end
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) begin
      b = r2[127 - 8*i -: 8];
      exp_q.push_back({1'b1, (b == 8'h00) ? 8'h20 : b});
    end
  endfunction

  function automatic void push_init();
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b0, 8'h32});
    exp_q.push_back({1'b0, 8'h28});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endfunction

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk) refresh_req = 1'b1;
    @(negedge clk) refresh_req = 1'b0;
  endtask

  task automatic test_reset();
    int cnt = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (lcd_valid !== 1'b0) begin errs++; $display("FAIL reset lcd_valid: got %b want 0", lcd_valid); end
    if (lcd_data !== 8'h00) begin errs++; $display("FAIL reset lcd_data: got %h want 00", lcd_data); end
    if (lcd_rs !== 1'b0) begin errs++; $display("FAIL reset lcd_rs: got %b want 0", lcd_rs); end
    if (init_done !== 1'b0) begin errs++; $display("FAIL reset init_done: got %b want 0", init_done); end
    if (busy !== 1'b1) begin errs++; $display("FAIL reset busy: got %b want 1", busy); end
    push_init();
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1 cnt++;
      if (lcd_valid) break;
    end
    total++;
    if (cnt !== 10) begin errs++; $display("FAIL power wait: got %0d cycles want 10", cnt); end
  endtask

  task automatic test_init();
    bit ok;
    logic [8:0] e;
    rx_t a;
    int unsigned last_c = 0, done_c = 0;
    wait_rx(6, 100, ok);
    total++;
    if (!ok) begin errs++; $display("FAIL init timeout: got %0d bytes want 6", rx.size()); end
    while (exp_q.size() > 0 && rx.size() > 0) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      last_c = a.c;
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL init byte: got rs=%b data=%h want rs=%b data=%h", a.rs, a.d, e[8], e[7:0]); end
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1 if (init_done) begin done_c = cyc; break; end
    end
    total++;
    if (done_c - last_c !== 5) begin errs++; $display("FAIL clear wait: got %0d cycles want 5", done_c - last_c); end
    repeat (3) @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin errs++; $display("FAIL blank idle busy: got %b want 0", busy); end
    if (lcd_valid !== 1'b0) begin errs++; $display("FAIL blank idle valid: got %b want 0", lcd_valid); end
  endtask

  task automatic test_frame();
    bit ok;
    logic [8:0] e;
    rx_t a;
    int unsigned first_c = 0, last_c = 0;
    @(negedge clk);
    row1 = COTTON;
    row2 = TIMER;
    push_frame(COTTON, TIMER);
    wait_rx(34, 200, ok);
    total++;
    if (!ok) begin errs++; $display("FAIL frame timeout: got %0d bytes want 34", rx.size()); end
    if (rx.size() > 0) first_c = rx[0].c;
    while (exp_q.size() > 0 && rx.size() > 0) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      last_c = a.c;
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL frame byte: got rs=%b data=%h want rs=%b data=%h", a.rs, a.d, e[8], e[7:0]); end
    end
    total++;
    if (last_c - first_c !== 33) begin errs++; $display("FAIL frame span: got %0d cycles want 33", last_c - first_c); end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin errs++; $display("FAIL frame busy after: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    bit ok = 1'b0;
    logic [8:0] e;
    rx_t a;
    viol = 0;
    push_frame(COTTON, TIMER);
    pulse_refresh();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk) lcd_ready = 1'($urandom_range(0, 1));
      if (rx.size() >= 34) begin ok = 1'b1; break; end
    end
    lcd_ready = 1'b1;
    total++;
    if (!ok) begin errs++; $display("FAIL stall timeout: got %0d bytes want 34", rx.size()); end
    repeat (4) @(negedge clk);
    total++;
    if (rx.size() !== 34) begin errs++; $display("FAIL stall count: got %0d bytes want 34", rx.size()); end
    while (exp_q.size() > 0 && rx.size() > 0) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL stall byte: got rs=%b data=%h want rs=%b data=%h", a.rs, a.d, e[8], e[7:0]); end
    end
    rx.delete();
    total++;
    if (viol !== 0) begin errs++; $display("FAIL stall hold: got %0d unstable cycles want 0", viol); end
  endtask

  task automatic test_midframe();
    bit ok;
    logic [8:0] e;
    rx_t a;
    int unsigned prev_c = 0;
    int gap = 0;
    push_frame(COTTON, TIMER);
    push_frame(WOODY, TIMER);
    pulse_refresh();
    wait_rx(10, 100, ok);
    row1 = WOODY;
    wait_rx(68, 300, ok);
    total++;
    if (!ok) begin errs++; $display("FAIL midframe timeout: got %0d bytes want 68", rx.size()); end
    for (int i = 0; exp_q.size() > 0 && rx.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      if (i == 34) gap = int'(a.c - prev_c);
      prev_c = a.c;
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL midframe byte %0d: got rs=%b data=%h want rs=%b data=%h", i, a.rs, a.d, e[8], e[7:0]); end
    end
    total++;
    if (gap < 2) begin errs++; $display("FAIL frame gap: got %0d cycles want >=2", gap); end
  endtask

  task automatic test_nul_refresh();
    bit ok;
    logic [8:0] e;
    rx_t a;
    logic [127:0] n1 = {8'h41, 8'h00, 8'h42, 8'h00, 96'h0};
    logic [127:0] n2 = {"xyz", 104'h0};
    @(negedge clk);
    row1 = n1;
    row2 = n2;
    push_frame(n1, n2);
    wait_rx(34, 200, ok);
    repeat (3) @(negedge clk);
    push_frame(n1, n2);
    pulse_refresh();
    wait_rx(68, 300, ok);
    total++;
    if (!ok) begin errs++; $display("FAIL nul timeout: got %0d bytes want 68", rx.size()); end
    while (exp_q.size() > 0 && rx.size() > 0) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL nul byte: got rs=%b data=%h want rs=%b data=%h", a.rs, a.d, e[8], e[7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [8:0] e;
    rx_t a;
    pulse_refresh();
    wait_rx(22, 200, ok);
    #2 rst = 1'b0;
    #1;
    total += 3;
    if (lcd_valid !== 1'b0) begin errs++; $display("FAIL midreset valid: got %b want 0", lcd_valid); end
    if (busy !== 1'b1) begin errs++; $display("FAIL midreset busy: got %b want 1", busy); end
    if (init_done !== 1'b0) begin errs++; $display("FAIL midreset init_done: got %b want 0", init_done); end
    repeat (2) @(negedge clk);
    rx.delete();
    exp_q.delete();
    push_init();
    push_frame(row1, row2);
    rst = 1'b1;
    wait_rx(40, 300, ok);
    total++;
    if (!ok) begin errs++; $display("FAIL midreset timeout: got %0d bytes want 40", rx.size()); end
    while (exp_q.size() > 0 && rx.size() > 0) begin
      e = exp_q.pop_front();
      a = rx.pop_front();
      total++;
      if ({a.rs, a.d} !== e) begin errs++; $display("FAIL midreset byte: got rs=%b data=%h want rs=%b data=%h", a.rs, a.d, e[8], e[7:0]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    lcd_ready = 1'b1;
    refresh_req = 1'b0;
    row1 = BLANK;
    row2 = BLANK;
    test_reset();
    test_init();
    test_frame();
    test_stall();
    test_midframe();
    test_nul_refresh();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end
endmodule
